// File: rtl/layer_macc_sequencer_if.sv
// Control bundle between the layer sequencer and its surroundings:
// start/result handshake toward the emulator, ROM and MACC strobes toward the datapath.
interface layer_macc_sequencer_if #(
    parameter int IN_W = 2,
    parameter int LY_W = 1
);
    logic            START;
    logic            OUT_READY;
    logic            ROM_RESET;
    logic            MACC_EN;
    logic            ACC_EN;
    logic [IN_W-1:0] IN_SEL;
    logic [LY_W-1:0] LAYER_IDX;
    logic            OUT_VALID;
    logic            BUSY;
    logic            DONE;

    modport master (
        input  START, OUT_READY,
        output ROM_RESET, MACC_EN, ACC_EN, IN_SEL,
        output LAYER_IDX, OUT_VALID, BUSY, DONE
    );

    modport slave (
        output START, OUT_READY,
        input  ROM_RESET, MACC_EN, ACC_EN, IN_SEL,
        input  LAYER_IDX, OUT_VALID, BUSY, DONE
    );
endinterface

// File: rtl/layer_macc_sequencer.sv
// Sequences one neuron-layer evaluation per layer over the weight ROM and
// the floating-point MACC, then hands each layer result off via valid/ready.
module layer_macc_sequencer #(
    parameter int N_INPUTS     = 4,
    parameter int MACC_LATENCY = 3,
    parameter int NUM_LAYERS   = 2
) (
    input  logic                   CLK,
    input  logic                   RESET,
    layer_macc_sequencer_if.master bus
);
    localparam int IN_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int LY_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int DR_W = (MACC_LATENCY > 1) ? $clog2(MACC_LATENCY) : 1;

    localparam logic [IN_W-1:0] TERM_LAST  = IN_W'(N_INPUTS - 1);
    localparam logic [LY_W-1:0] LAYER_LAST = LY_W'(NUM_LAYERS - 1);
    localparam logic [DR_W-1:0] DRAIN_INIT =
        DR_W'((MACC_LATENCY > 0) ? MACC_LATENCY - 1 : 0);

    typedef enum logic [2:0] {
        IDLE, PRIME, STREAM, DRAIN, OUTPUT
    } state_t;

    state_t          state, state_n;
    logic [IN_W-1:0] term, term_n;
    logic [LY_W-1:0] layer, layer_n;
    logic [DR_W-1:0] drain, drain_n;
    logic            done_q, done_n;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= IDLE;
            term   <= '0;
            layer  <= '0;
            drain  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            term   <= term_n;
            layer  <= layer_n;
            drain  <= drain_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        term_n  = term;
        layer_n = layer;
        drain_n = drain;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.START) begin
                    state_n = PRIME;
                    layer_n = '0;
                end
            end
            PRIME: begin
                state_n = STREAM;
                term_n  = '0;
            end
            STREAM: begin
                if (term == TERM_LAST) begin
                    // a zero-latency MACC has nothing to wait out
                    if (MACC_LATENCY > 0) begin
                        state_n = DRAIN;
                        drain_n = DRAIN_INIT;
                    end else begin
                        state_n = OUTPUT;
                    end
                end else begin
                    term_n = term + 1'b1;
                end
            end
            DRAIN: begin
                if (drain == '0) state_n = OUTPUT;
                else             drain_n = drain - 1'b1;
            end
            OUTPUT: begin
                if (bus.OUT_READY) begin
                    if (layer == LAYER_LAST) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        layer_n = '0;
                        term_n  = '0;
                    end else begin
                        state_n = PRIME;
                        layer_n = layer + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.ROM_RESET = (state == PRIME);
    assign bus.MACC_EN   = (state == STREAM);
    assign bus.ACC_EN    = (state == STREAM) && (term != '0);
    assign bus.IN_SEL    = (state == STREAM) ? term : '0;
    assign bus.LAYER_IDX = (state != IDLE) ? layer : '0;
    assign bus.OUT_VALID = (state == OUTPUT);
    assign bus.BUSY      = (state != IDLE);
    assign bus.DONE      = done_q;
endmodule

// File: tb/tb_layer_macc_sequencer.sv
// Directed cycle-by-cycle bench for the layer sequencer: default build
// plus a minimal-parameter build sharing the same clock and reset.
module tb_layer_macc_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    layer_macc_sequencer_if #(.IN_W(2), .LY_W(1)) m ();
    layer_macc_sequencer_if #(.IN_W(1), .LY_W(1)) c ();

    layer_macc_sequencer #(
        .N_INPUTS(4), .MACC_LATENCY(3), .NUM_LAYERS(2)
    ) dut (
        .CLK(clk), .RESET(rst), .bus(m.master)
    );

    layer_macc_sequencer #(
        .N_INPUTS(1), .MACC_LATENCY(0), .NUM_LAYERS(1)
    ) dut_c (
        .CLK(clk), .RESET(rst), .bus(c.master)
    );

    // {ROM_RESET, MACC_EN, ACC_EN, IN_SEL[1:0], LAYER_IDX, OUT_VALID, BUSY, DONE}
    logic [8:0] mo, co;
    assign mo = {m.ROM_RESET, m.MACC_EN, m.ACC_EN, m.IN_SEL,
                 m.LAYER_IDX, m.OUT_VALID, m.BUSY, m.DONE};
    assign co = {c.ROM_RESET, c.MACC_EN, c.ACC_EN, 1'b0, c.IN_SEL,
                 c.LAYER_IDX, c.OUT_VALID, c.BUSY, c.DONE};

    function automatic logic [8:0] ev(
        input logic rr, input logic me, input logic ae,
        input logic [1:0] sel, input logic li,
        input logic ov, input logic bz, input logic dn
    );
        return {rr, me, ae, sel, li, ov, bz, dn};
    endfunction

    task automatic check(input string tag, input logic [8:0] got,
                         input logic [8:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One layer: PRIME, 4 STREAM, 3 DRAIN, OUTPUT held w extra cycles.
    // pk >= 0 raises START for one cycle at that stream index.
    task automatic layer(input int l, input int w, input int pk);
        logic li;
        li = l[0];
        tick();
        check($sformatf("L%0d prime", l), mo, ev(1, 0, 0, 2'd0, li, 0, 1, 0));
        m.START = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("L%0d stream%0d", l, k), mo,
                  ev(0, 1, k != 0, 2'(k), li, 0, 1, 0));
            m.START = (k == pk);
        end
        for (int d = 0; d < 3; d++) begin
            tick();
            check($sformatf("L%0d drain%0d", l, d), mo,
                  ev(0, 0, 0, 2'd0, li, 0, 1, 0));
        end
        for (int i = 0; i <= w; i++) begin
            tick();
            check($sformatf("L%0d out%0d", l, i), mo,
                  ev(0, 0, 0, 2'd0, li, 1, 1, 0));
            m.OUT_READY = (i >= w);
        end
    endtask

    task automatic run_eval(input int w0, input int w1, input int pk);
        if (w0 > 0) m.OUT_READY = 1'b0;
        layer(0, w0, pk);
        if (w1 > 0) m.OUT_READY = 1'b0;
        layer(1, w1, -1);
        tick();
        check("done", mo, ev(0, 0, 0, 2'd0, 0, 0, 0, 1));
    endtask

    task automatic idle_chk(input string tag);
        tick();
        check(tag, mo, ev(0, 0, 0, 2'd0, 0, 0, 0, 0));
    endtask

    initial begin
        rst         = 1'b1;
        m.START     = 1'b1;
        m.OUT_READY = 1'b1;
        c.START     = 1'b0;
        c.OUT_READY = 1'b1;

        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst%0d", i), mo, 9'd0);
            check($sformatf("rst_c%0d", i), co, 9'd0);
        end
        rst = 1'b0;

        // nominal: START still high from reset phase
        run_eval(0, 0, -1);
        idle_chk("post_nom");

        // backpressure on layer 0
        m.START = 1'b1;
        run_eval(5, 0, -1);
        idle_chk("post_bp");

        // START pulse mid-stream ignored, then restart in DONE cycle
        m.START = 1'b1;
        run_eval(0, 0, 2);
        m.START = 1'b1;
        run_eval(0, 0, -1);
        idle_chk("post_b2b");

        // reset during DRAIN
        m.START = 1'b1;
        tick();
        check("mr prime", mo, ev(1, 0, 0, 2'd0, 0, 0, 1, 0));
        m.START = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        tick();
        check("mr drain6", mo, ev(0, 0, 0, 2'd0, 0, 0, 1, 0));
        tick();
        check("mr drain7", mo, ev(0, 0, 0, 2'd0, 0, 0, 1, 0));
        rst = 1'b1;
        idle_chk("mr rst");
        rst = 1'b0;
        idle_chk("mr nodone");
        m.START = 1'b1;
        run_eval(0, 0, -1);
        idle_chk("post_mr");

        // minimal-parameter build
        c.START = 1'b1;
        tick();
        check("c prime", co, ev(1, 0, 0, 2'd0, 0, 0, 1, 0));
        c.START = 1'b0;
        tick();
        check("c stream", co, ev(0, 1, 0, 2'd0, 0, 0, 1, 0));
        tick();
        check("c out", co, ev(0, 0, 0, 2'd0, 0, 1, 1, 0));
        tick();
        check("c done", co, ev(0, 0, 0, 2'd0, 0, 0, 0, 1));
        tick();
        check("c idle", co, ev(0, 0, 0, 2'd0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
